// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle RISC-V core: per-cycle
// retire enable, two PC breakpoints and a retired-instruction counter.
module cpu_run_ctrl #(
  parameter int ADDRWIDTH = 32,
  parameter int CNTWIDTH  = 32
) (
  input  logic                 iCPU_Clk,
  input  logic                 iCPU_Reset,
  input  logic                 iCmd_Valid,
  input  logic [2:0]           iCmd,
  input  logic                 iCmd_Idx,
  input  logic [ADDRWIDTH-1:0] iCmd_Data,
  output logic                 oCmd_Ready,
  input  logic [ADDRWIDTH-1:0] iCurrent_PC,
  output logic                 oCommit,
  output logic [1:0]           oState,
  output logic                 oHalted,
  output logic                 oBkpt_Hit,
  output logic                 oBkpt_Id,
  output logic                 oStep_Done,
  output logic [CNTWIDTH-1:0]  oInstr_Cnt
);

  // Command port handshake: a command is taken on a rising edge exactly when
  // iCmd_Valid & oCmd_Ready; oCmd_Ready depends on state only and is low in STEP.

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_RUN    = 3'd1,
    CMD_HALT   = 3'd2,
    CMD_STEP   = 3'd3,
    CMD_SETBP  = 3'd4,
    CMD_CLRBP  = 3'd5,
    CMD_CLRCNT = 3'd6
  } cmd_e;

  localparam logic [CNTWIDTH-1:0] CNT_ONE = 1;
  localparam int                  BPW     = ADDRWIDTH - 2;

  state_e                   state_q, state_d;
  logic                     skip_q, skip_d;
  logic                     hit_q, hit_d;
  logic                     id_q, id_d;
  logic                     step_done_q, step_done_d;
  logic [CNTWIDTH-1:0]      cnt_q, cnt_d;
  logic [1:0]               bp_en_q, bp_en_d;
  logic [1:0][BPW-1:0]      bp_addr_q, bp_addr_d;

  logic                     cmd_acc;
  logic [1:0]               bp_match;
  logic                     bp_fire;
  logic                     unused_addr_lsbs;

  // Breakpoints compare word addresses only, so the low PC bits never matter.
  assign unused_addr_lsbs = ^{iCmd_Data[1:0], iCurrent_PC[1:0]};

  always_comb begin
    oCmd_Ready = (state_q != ST_STEP);
    cmd_acc    = iCmd_Valid & oCmd_Ready;
    for (int i = 0; i < 2; i++) begin
      bp_match[i] = bp_en_q[i] & (bp_addr_q[i] == iCurrent_PC[ADDRWIDTH-1:2]);
    end
    bp_fire = (state_q == ST_RUN) & (|bp_match) & ~skip_q;
    oCommit = ((state_q == ST_RUN) & ~bp_fire) | (state_q == ST_STEP);
  end

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    hit_d       = hit_q;
    id_d        = id_q;
    step_done_d = 1'b0;

    if (cmd_acc && (iCmd == CMD_RUN || iCmd == CMD_STEP)) begin
      hit_d = 1'b0;
    end

    case (state_q)
      ST_HALT: begin
        if (cmd_acc && iCmd == CMD_RUN) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (cmd_acc && iCmd == CMD_STEP) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        skip_d = 1'b0;
        // A breakpoint outranks a same-cycle HALT so the hit is still reported.
        if (bp_fire) begin
          state_d = ST_HALT;
          hit_d   = 1'b1;
          id_d    = ~bp_match[0];
        end else if (cmd_acc && iCmd == CMD_HALT) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        state_d     = ST_HALT;
        step_done_d = 1'b1;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_comb begin
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    if (cmd_acc && iCmd == CMD_SETBP) begin
      bp_en_d[iCmd_Idx]   = 1'b1;
      bp_addr_d[iCmd_Idx] = iCmd_Data[ADDRWIDTH-1:2];
    end else if (cmd_acc && iCmd == CMD_CLRBP) begin
      bp_en_d[iCmd_Idx] = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cmd_acc && iCmd == CMD_CLRCNT) begin
      cnt_d = '0;
    end else if (oCommit) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge iCPU_Clk or negedge iCPU_Reset) begin
    if (!iCPU_Reset) begin
      state_q     <= ST_HALT;
      skip_q      <= 1'b0;
      hit_q       <= 1'b0;
      id_q        <= 1'b0;
      step_done_q <= 1'b0;
      cnt_q       <= '0;
      bp_en_q     <= '0;
      bp_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      hit_q       <= hit_d;
      id_q        <= id_d;
      step_done_q <= step_done_d;
      cnt_q       <= cnt_d;
      bp_en_q     <= bp_en_d;
      bp_addr_q   <= bp_addr_d;
    end
  end

  assign oState     = state_q;
  assign oHalted    = (state_q == ST_HALT);
  assign oBkpt_Hit  = hit_q;
  assign oBkpt_Id   = id_q;
  assign oStep_Done = step_done_q;
  assign oInstr_Cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: vector table of per-cycle stimulus and expected outputs,
// plus hand-written reset sequences.
module tb_cpu_run_ctrl;

  localparam int AW = 32;
  localparam int CW = 4;
  localparam int EW = 2 + 1 + 1 + 1 + CW;

  localparam logic [2:0] C_NOP = 3'd0, C_RUN = 3'd1, C_HALT = 3'd2, C_STEP = 3'd3;
  localparam logic [2:0] C_SETBP = 3'd4, C_CLRBP = 3'd5, C_CLRCNT = 3'd6, C_RSVD = 3'd7;
  localparam logic [1:0] S_HALT = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic          cmd_idx;
  logic [AW-1:0] cmd_data;
  logic          cmd_ready;
  logic [AW-1:0] cur_pc;
  logic          commit;
  logic [1:0]    state;
  logic          halted;
  logic          bkpt_hit;
  logic          bkpt_id;
  logic          step_done;
  logic [CW-1:0] instr_cnt;

  cpu_run_ctrl #(.ADDRWIDTH(AW), .CNTWIDTH(CW)) dut (
    .iCPU_Clk    (clk),
    .iCPU_Reset  (rst_n),
    .iCmd_Valid  (cmd_valid),
    .iCmd        (cmd),
    .iCmd_Idx    (cmd_idx),
    .iCmd_Data   (cmd_data),
    .oCmd_Ready  (cmd_ready),
    .iCurrent_PC (cur_pc),
    .oCommit     (commit),
    .oState      (state),
    .oHalted     (halted),
    .oBkpt_Hit   (bkpt_hit),
    .oBkpt_Id    (bkpt_id),
    .oStep_Done  (step_done),
    .oInstr_Cnt  (instr_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [2:0]    c;
    logic          idx;
    logic [AW-1:0] data;
    logic [AW-1:0] pc;
    logic          e_commit;
    logic          e_ready;
    logic [1:0]    e_state;
    logic          e_hit;
    logic          e_id;
    logic          e_done;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t          tbl[$];
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic add(input logic v, input logic [2:0] c, input logic idx,
                     input logic [AW-1:0] data, input logic [AW-1:0] pc,
                     input logic ec, input logic er, input logic [1:0] es,
                     input logic eh, input logic ei, input logic ed,
                     input logic [CW-1:0] ecnt);
    vec_t t;
    t.v = v; t.c = c; t.idx = idx; t.data = data; t.pc = pc;
    t.e_commit = ec; t.e_ready = er; t.e_state = es;
    t.e_hit = eh; t.e_id = ei; t.e_done = ed; t.e_cnt = ecnt;
    tbl.push_back(t);
  endtask

  // Driver: one vector per cycle, inputs on the falling edge, combinational
  // outputs checked just after, registered outputs checked after the next rise.
  task automatic run_table(input string tag);
    logic [EW-1:0] e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      cmd_valid = tbl[i].v;
      cmd       = tbl[i].c;
      cmd_idx   = tbl[i].idx;
      cmd_data  = tbl[i].data;
      cur_pc    = tbl[i].pc;
      #1;
      chk($sformatf("%s[%0d] commit", tag, i), {31'd0, commit}, {31'd0, tbl[i].e_commit});
      chk($sformatf("%s[%0d] ready", tag, i), {31'd0, cmd_ready}, {31'd0, tbl[i].e_ready});
      exp_q.push_back({tbl[i].e_state, tbl[i].e_hit, tbl[i].e_id, tbl[i].e_done, tbl[i].e_cnt});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk($sformatf("%s[%0d] scoreboard empty", tag, i), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s[%0d] state", tag, i), {30'd0, state}, {30'd0, e[EW-1 -: 2]});
        chk($sformatf("%s[%0d] halted", tag, i), {31'd0, halted}, {31'd0, (e[EW-1 -: 2] == S_HALT)});
        chk($sformatf("%s[%0d] bkpt_hit", tag, i), {31'd0, bkpt_hit}, {31'd0, e[CW+2]});
        chk($sformatf("%s[%0d] bkpt_id", tag, i), {31'd0, bkpt_id}, {31'd0, e[CW+1]});
        chk($sformatf("%s[%0d] step_done", tag, i), {31'd0, step_done}, {31'd0, e[CW]});
        chk($sformatf("%s[%0d] instr_cnt", tag, i), {28'd0, instr_cnt}, {28'd0, e[CW-1:0]});
      end
    end
    tbl.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"}, {30'd0, state}, {30'd0, S_HALT});
    chk({tag, " commit"}, {31'd0, commit}, 32'd0);
    chk({tag, " ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, " halted"}, {31'd0, halted}, 32'd1);
    chk({tag, " bkpt_hit"}, {31'd0, bkpt_hit}, 32'd0);
    chk({tag, " bkpt_id"}, {31'd0, bkpt_id}, 32'd0);
    chk({tag, " step_done"}, {31'd0, step_done}, 32'd0);
    chk({tag, " instr_cnt"}, {28'd0, instr_cnt}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = C_NOP; cmd_idx = 1'b0;
    cmd_data = '0; cur_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_vals("reset");

    // Run from reset, ten commits, then HALT in RUN
    add(1, C_RUN, 0, 0, 32'h0, 0, 1, S_RUN, 0, 0, 0, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      add(0, C_NOP, 0, 0, 32'(4 * (k - 1)), 1, 1, S_RUN, 0, 0, 0, 4'(k));
    end
    add(1, C_HALT, 0, 0, 32'h28, 1, 1, S_HALT, 0, 0, 0, 4'd11);
    add(0, C_NOP, 0, 0, 32'h2C, 0, 1, S_HALT, 0, 0, 0, 4'd11);
    // Breakpoint 1 at 0x10, hit, resume with skip, counter wraps at 16
    add(1, C_SETBP, 1, 32'h10, 32'h0, 0, 1, S_HALT, 0, 0, 0, 4'd11);
    add(1, C_RUN, 0, 0, 32'h0, 0, 1, S_RUN, 0, 0, 0, 4'd11);
    add(0, C_NOP, 0, 0, 32'h8, 1, 1, S_RUN, 0, 0, 0, 4'd12);
    add(0, C_NOP, 0, 0, 32'hC, 1, 1, S_RUN, 0, 0, 0, 4'd13);
    add(0, C_NOP, 0, 0, 32'h10, 0, 1, S_HALT, 1, 1, 0, 4'd13);
    add(0, C_NOP, 0, 0, 32'h10, 0, 1, S_HALT, 1, 1, 0, 4'd13);
    add(1, C_RUN, 0, 0, 32'h10, 0, 1, S_RUN, 0, 1, 0, 4'd13);
    add(0, C_NOP, 0, 0, 32'h10, 1, 1, S_RUN, 0, 1, 0, 4'd14);
    add(0, C_NOP, 0, 0, 32'h14, 1, 1, S_RUN, 0, 1, 0, 4'd15);
    add(0, C_NOP, 0, 0, 32'h18, 1, 1, S_RUN, 0, 1, 0, 4'd0);
    // Breakpoint and HALT in the same cycle
    add(1, C_HALT, 0, 0, 32'h10, 0, 1, S_HALT, 1, 1, 0, 4'd0);
    // Step on a breakpoint PC; CLRCNT offered during STEP is not taken
    add(1, C_STEP, 0, 0, 32'h10, 0, 1, S_STEP, 0, 1, 0, 4'd0);
    add(1, C_CLRCNT, 0, 0, 32'h10, 1, 0, S_HALT, 0, 1, 1, 4'd1);
    add(0, C_NOP, 0, 0, 32'h14, 0, 1, S_HALT, 0, 1, 0, 4'd1);
    // Both breakpoints match (0x12 ignores low bits): lowest index wins
    add(1, C_SETBP, 0, 32'h12, 32'h14, 0, 1, S_HALT, 0, 1, 0, 4'd1);
    add(1, C_RUN, 0, 0, 32'h14, 0, 1, S_RUN, 0, 1, 0, 4'd1);
    add(0, C_NOP, 0, 0, 32'h14, 1, 1, S_RUN, 0, 1, 0, 4'd2);
    add(0, C_NOP, 0, 0, 32'h10, 0, 1, S_HALT, 1, 0, 0, 4'd2);
    // Clear breakpoints while running: no break at the old address
    add(1, C_RUN, 0, 0, 32'h10, 0, 1, S_RUN, 0, 0, 0, 4'd2);
    add(1, C_CLRBP, 0, 0, 32'h10, 1, 1, S_RUN, 0, 0, 0, 4'd3);
    add(1, C_CLRBP, 1, 0, 32'h20, 1, 1, S_RUN, 0, 0, 0, 4'd4);
    add(0, C_NOP, 0, 0, 32'h10, 1, 1, S_RUN, 0, 0, 0, 4'd5);
    // CLRCNT with a commit, reserved/RUN/invalid commands while running
    add(1, C_CLRCNT, 0, 0, 32'h14, 1, 1, S_RUN, 0, 0, 0, 4'd0);
    add(0, C_NOP, 0, 0, 32'h18, 1, 1, S_RUN, 0, 0, 0, 4'd1);
    add(1, C_RSVD, 0, 0, 32'h1C, 1, 1, S_RUN, 0, 0, 0, 4'd2);
    add(1, C_RUN, 0, 0, 32'h20, 1, 1, S_RUN, 0, 0, 0, 4'd3);
    add(0, C_HALT, 0, 0, 32'h24, 1, 1, S_RUN, 0, 0, 0, 4'd4);
    add(1, C_SETBP, 0, 32'h40, 32'h28, 1, 1, S_RUN, 0, 0, 0, 4'd5);
    run_table("p1");

    // Asynchronous reset between edges while running
    @(negedge clk);
    cmd_valid = 1'b0; cmd = C_NOP; cur_pc = 32'h2C;
    #1;
    chk("pre_reset commit", {31'd0, commit}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_vals("post_release");

    // Breakpoint set before reset must be gone afterwards
    add(1, C_RUN, 0, 0, 32'h40, 0, 1, S_RUN, 0, 0, 0, 4'd0);
    add(0, C_NOP, 0, 0, 32'h44, 1, 1, S_RUN, 0, 0, 0, 4'd1);
    add(0, C_NOP, 0, 0, 32'h40, 1, 1, S_RUN, 0, 0, 0, 4'd2);
    add(1, C_HALT, 0, 0, 32'h48, 1, 1, S_HALT, 0, 0, 0, 4'd3);
    run_table("p2");

    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
